// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, filter latency and sequencer FSM states
// used by the FIR filter and its sample sequencer.
package fir_pkg;

  localparam int FIR_WI1 = 4;
  localparam int FIR_WF1 = 5;
  localparam int FIR_WOI = 12;
  localparam int FIR_WOF = 10;
  localparam int FIR_LAT = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/fir_sample_ram.sv
// fir_sample_ram: sample store, single write port,
// registered read with read enable (output holds when re=0).
module fir_sample_ram #(
  parameter int DEPTH = 50,
  parameter int AW    = 6,
  parameter int DW    = 9
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // out-of-range writes are dropped; contents survive reset
  always_ff @(posedge CLK) begin
    if (we && (int'(waddr) < DEPTH))
      mem[waddr] <= wdata;
  end

  // read register doubles as the filter's X output
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      rdata <= '0;
    else if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/fir_sample_sequencer.sv
// fir_sample_sequencer: plays stored samples into a FIR, captures results.
// Optional FIR_SEQ_OVF_CNT_EN adds a saturating overflow counter port.
module fir_sample_sequencer
  import fir_pkg::*;
#(
  parameter int No_Input = 50,
  parameter int AW       = 6,
  parameter int WI1      = FIR_WI1,
  parameter int WF1      = FIR_WF1,
  parameter int WOI      = FIR_WOI,
  parameter int WOF      = FIR_WOF,
  parameter int WAIT_CYC = FIR_LAT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 load_we,
  input  logic [AW-1:0]        load_addr,
  input  logic [WI1+WF1-1:0]   load_data,
  input  logic                 start,
  input  logic [AW-1:0]        run_len,
  output logic [WI1+WF1-1:0]   X,
  output logic                 test,
  input  logic [WOI+WOF-1:0]   Filt_Out,
  input  logic                 overflow,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WOI+WOF-1:0]   res_data,
  output logic                 res_ovf,
  output logic [AW-1:0]        res_idx,
  output logic                 busy,
  output logic                 done
`ifdef FIR_SEQ_OVF_CNT_EN
  ,
  output logic [AW-1:0]        ovf_count
`endif
);

  localparam int DW = WI1 + WF1;
  localparam logic [7:0] CNT_INIT = 8'(WAIT_CYC - 1);
  localparam logic [AW-1:0] ONE = AW'(1);

  seq_state_t    state, state_nxt;
  logic [AW-1:0] idx, len, len_req, raddr;
  logic [7:0]    cnt;
  logic          start_ok, cap, hs, last, re, we;

  assign start_ok = (state == S_IDLE) && start;
  assign len_req  = (int'(run_len) > No_Input) ? AW'(No_Input) : run_len;
  assign cap      = (state == S_WAIT) && (cnt == '0);
  assign hs       = (state == S_HOLD) && res_valid && res_ready;
  assign last     = (idx == len - ONE);
  assign we       = (state == S_IDLE) && load_we;
  assign raddr    = (state == S_IDLE) ? '0 : idx + ONE;
  assign re       = (state_nxt == S_ISSUE);
  assign test     = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  fir_sample_ram #(
    .DEPTH (No_Input),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (re),
    .raddr (raddr),
    .rdata (X)
  );

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // next-state: one frame is ISSUE, WAIT..., HOLD until handshake
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start)
                 state_nxt = (len_req == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_HOLD;
      S_HOLD:  if (hs) state_nxt = last ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // run bookkeeping, latency counter and result capture
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx       <= '0;
      len       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      res_idx   <= '0;
    end else begin
      if (start_ok) begin
        len <= len_req;
        idx <= '0;
      end
      if (state == S_ISSUE)
        cnt <= CNT_INIT;
      else if ((state == S_WAIT) && (cnt != '0))
        cnt <= cnt - 8'd1;
      if (cap) begin
        res_valid <= 1'b1;
        res_data  <= Filt_Out;
        res_ovf   <= overflow;
        res_idx   <= idx;
      end else if (hs) begin
        res_valid <= 1'b0;
      end
      if (hs && !last)
        idx <= idx + ONE;
    end
  end

`ifdef FIR_SEQ_OVF_CNT_EN
  // overflow captures per run, saturating
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      ovf_count <= '0;
    else if (start_ok)
      ovf_count <= '0;
    else if (cap && overflow && (ovf_count != '1))
      ovf_count <= ovf_count + ONE;
  end
`endif

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// tb_fir_sample_sequencer: directed checks of sequencing,
// capture timing, back-pressure, clamping and reset abort.
module tb_fir_sample_sequencer;

  localparam logic [21:0] JUNK = 22'h155555;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        load_we;
  logic [5:0]  load_addr;
  logic [8:0]  load_data;
  logic        start;
  logic [5:0]  run_len;
  logic [8:0]  X;
  logic        test;
  logic [21:0] Filt_Out;
  logic        overflow;
  logic        res_valid;
  logic        res_ready;
  logic [21:0] res_data;
  logic        res_ovf;
  logic [5:0]  res_idx;
  logic        busy;
  logic        done;
`ifdef FIR_SEQ_OVF_CNT_EN
  logic [5:0]  ovf_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [8:0]  smp;
    logic [21:0] fv;
    logic        ov;
    logic [5:0]  idx;
  } vec_t;

  vec_t vec [3];

  fir_sample_sequencer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .run_len   (run_len),
    .X         (X),
    .test      (test),
    .Filt_Out  (Filt_Out),
    .overflow  (overflow),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .res_idx   (res_idx),
    .busy      (busy),
    .done      (done)
`ifdef FIR_SEQ_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_X", 32'(X), 32'h0);
    chk("rst_test", 32'(test), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'h0);
    chk("rst_data", 32'(res_data), 32'h0);
    chk("rst_ovf", 32'(res_ovf), 32'h0);
    chk("rst_idx", 32'(res_idx), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
  endtask

  task automatic load(input logic [5:0] a, input logic [8:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge CLK);
    load_we = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] n);
    start = 1'b1; run_len = n;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // entered at the negedge of the test cycle; returns at the
  // negedge of the cycle after the result handshake
  task automatic frame(input vec_t v, input bit hold);
    chk("test_hi", 32'(test), 32'h1);
    chk("x", 32'(X), 32'(v.smp));
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i == 0) chk("test_lo", 32'(test), 32'h0);
      if (i == 5) chk("early_valid", 32'(res_valid), 32'h0);
    end
    Filt_Out = v.fv; overflow = v.ov;
    if (hold) res_ready = 1'b0;
    @(negedge CLK);
    Filt_Out = JUNK; overflow = 1'b0;
    chk("res_valid", 32'(res_valid), 32'h1);
    chk("res_data", 32'(res_data), 32'(v.fv));
    chk("res_ovf", 32'(res_ovf), 32'(v.ov));
    chk("res_idx", 32'(res_idx), 32'(v.idx));
    if (hold) begin
      load_we = 1'b1; load_addr = 6'd0; load_data = 9'h0F0;
      start = 1'b1; run_len = 6'd1;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        load_we = 1'b0; start = 1'b0;
        chk("bp_valid", 32'(res_valid), 32'h1);
        chk("bp_data", 32'(res_data), 32'(v.fv));
        chk("bp_test", 32'(test), 32'h0);
      end
      res_ready = 1'b1;
    end
    @(negedge CLK);
    chk("valid_clr", 32'(res_valid), 32'h0);
  endtask

  task automatic play(input int n, input int hold_at);
    for (int i = 0; i < n; i++) frame(vec[i], i == hold_at);
    chk("done_hi", 32'(done), 32'h1);
    chk("busy_done", 32'(busy), 32'h1);
    start = 1'b1; run_len = 6'd3;
    @(negedge CLK);
    start = 1'b0;
    chk("done_lo", 32'(done), 32'h0);
    chk("start_on_done", 32'(busy), 32'h0);
    chk("no_test", 32'(test), 32'h0);
  endtask

  initial begin
    int  cnt_res;
    logic [5:0] last_idx;
    bit  fin;

    vec[0] = '{smp: 9'h020, fv: 22'h0ABCDE, ov: 1'b1, idx: 6'd0};
    vec[1] = '{smp: 9'h1E0, fv: 22'h200001, ov: 1'b0, idx: 6'd1};
    vec[2] = '{smp: 9'h000, fv: 22'h3FF000, ov: 1'b1, idx: 6'd2};

    RESET = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; run_len = '0; Filt_Out = JUNK; overflow = 1'b0;
    res_ready = 1'b1;
    #1;
    chk_reset();
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 3; i++) load(6'(i), vec[i].smp);
    load(6'd50, 9'h0AA);

    // load and play, ready tied high
    do_start(6'd3);
    play(3, -1);
`ifdef FIR_SEQ_OVF_CNT_EN
    chk("ovf_count", 32'(ovf_count), 32'd2);
`endif

    // back-pressure on result 1, with ignored start/load
    do_start(6'd3);
    play(3, 1);
`ifdef FIR_SEQ_OVF_CNT_EN
    chk("ovf_count_bp", 32'(ovf_count), 32'd2);
`endif

    // empty run
    do_start(6'd0);
    chk("empty_done", 32'(done), 32'h1);
    chk("empty_test", 32'(test), 32'h0);
    @(negedge CLK);
    chk("empty_idle", 32'(busy), 32'h0);

    // clamp 63 -> 50
    cnt_res = 0; last_idx = '0; fin = 1'b0;
    do_start(6'd63);
    for (int c = 0; c < 1000 && !fin; c++) begin
      if (res_valid && res_ready) begin
        cnt_res++;
        last_idx = res_idx;
      end
      if (done) fin = 1'b1;
      else @(negedge CLK);
    end
    chk("clamp_finish", 32'(fin), 32'h1);
    chk("clamp_count", 32'(cnt_res), 32'd50);
    chk("clamp_last", 32'(last_idx), 32'd49);
    @(negedge CLK);

    // reset during WAIT of sample 2
    do_start(6'd3);
    frame(vec[0], 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk_reset();
`ifdef FIR_SEQ_OVF_CNT_EN
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("abort_no_done", 32'(done | busy), 32'h0);
    end
    do_start(6'd3);
    play(3, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
